fsm_moore_ascon_ctrl: RTL and testbench

//  Parametrised Moore FSM sequencing a full ASCON AEAD encryption: init, N associated-data blocks, domain separation, M plaintext blocks, finalisation, tag.

---
 rtl/fsm_moore_ascon_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_fsm_moore_ascon_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_moore_ascon_ctrl.sv
// Moore controller sequencing one ASCON AEAD encryption: init, AD blocks, domain separation,
// PT blocks, finalisation and tag. Every output is a registered decode of (state, round).
module fsm_moore_ascon_ctrl #(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 6,
  parameter int BLK_W     = 4,
  parameter int RND_W     = 4
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [BLK_W-1:0] nb_ad_i,
  input  logic [BLK_W-1:0] nb_pt_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic [RND_W-1:0] round_o,
  output logic             input_mode_o,
  output logic             en_reg_state_o,
  output logic             xor_data_o,
  output logic             xor_key_begin_o,
  output logic             xor_key_end_o,
  output logic             xor_dom_sep_o,
  output logic             en_cipher_o,
  output logic             en_tag_o,
  output logic             end_initialisation_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_INIT    = 4'd2,
    S_AD_WAIT = 4'd3,
    S_AD_RND  = 4'd4,
    S_DSEP    = 4'd5,
    S_PT_WAIT = 4'd6,
    S_PT_RND  = 4'd7,
    S_FIN     = 4'd8,
    S_TAG     = 4'd9
  } state_e;

  typedef struct packed {
    logic data_ready;
    logic input_mode;
    logic en_reg_state;
    logic xor_data;
    logic xor_key_begin;
    logic xor_key_end;
    logic xor_dom_sep;
    logic en_cipher;
    logic en_tag;
    logic end_init;
    logic busy;
    logic done;
  } ctrl_t;

  // Round counter holds the actual round-constant index; every phase ends on round 11.
  localparam logic [RND_W-1:0] RND_A0   = RND_W'(12 - PA_ROUNDS);
  localparam logic [RND_W-1:0] RND_B0   = RND_W'(12 - PB_ROUNDS);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(11);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

  state_e           state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [BLK_W-1:0] ad_q, ad_d, pt_q, pt_d;
  ctrl_t            out_q, out_d;
  logic             xfer;

  assign xfer = data_valid_i & ((state_q == S_AD_WAIT) | (state_q == S_PT_WAIT));

  function automatic ctrl_t decode(input state_e s, input logic [RND_W-1:0] r);
    ctrl_t c;
    c      = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_LOAD: begin
        c.input_mode   = 1'b1;
        c.en_reg_state = 1'b1;
      end
      S_INIT: begin
        c.en_reg_state = 1'b1;
        c.xor_key_end  = (r == RND_LAST);
        c.end_init     = (r == RND_LAST);
      end
      S_AD_WAIT, S_PT_WAIT: c.data_ready = 1'b1;
      S_AD_RND: begin
        c.en_reg_state = 1'b1;
        c.xor_data     = (r == RND_B0);
      end
      S_DSEP: begin
        c.en_reg_state = 1'b1;
        c.xor_dom_sep  = 1'b1;
      end
      S_PT_RND: begin
        c.en_reg_state = 1'b1;
        c.xor_data     = (r == RND_B0);
        c.en_cipher    = (r == RND_B0);
      end
      // Last PT block is absorbed on the first FIN cycle together with the key XOR.
      S_FIN: begin
        c.en_reg_state  = 1'b1;
        c.xor_data      = (r == RND_A0);
        c.en_cipher     = (r == RND_A0);
        c.xor_key_begin = (r == RND_A0);
        c.xor_key_end   = (r == RND_LAST);
      end
      S_TAG: begin
        c.en_tag = 1'b1;
        c.done   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    ad_d    = ad_q;
    pt_d    = pt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          ad_d    = nb_ad_i;
          pt_d    = (nb_pt_i == '0) ? BLK_ONE : nb_pt_i;
        end
      end
      S_LOAD: begin
        state_d = S_INIT;
        rnd_d   = RND_A0;
      end
      S_INIT: begin
        if (rnd_q == RND_LAST) begin
          rnd_d   = '0;
          state_d = (ad_q != '0) ? S_AD_WAIT : S_DSEP;
        end else begin
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      S_AD_WAIT: begin
        if (xfer) begin
          state_d = S_AD_RND;
          rnd_d   = RND_B0;
        end
      end
      S_AD_RND: begin
        if (rnd_q == RND_LAST) begin
          rnd_d   = '0;
          ad_d    = ad_q - BLK_ONE;
          state_d = (ad_q > BLK_ONE) ? S_AD_WAIT : S_DSEP;
        end else begin
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      S_DSEP: state_d = S_PT_WAIT;
      S_PT_WAIT: begin
        if (xfer) begin
          if (pt_q > BLK_ONE) begin
            state_d = S_PT_RND;
            rnd_d   = RND_B0;
          end else begin
            state_d = S_FIN;
            rnd_d   = RND_A0;
          end
        end
      end
      S_PT_RND: begin
        if (rnd_q == RND_LAST) begin
          rnd_d   = '0;
          pt_d    = pt_q - BLK_ONE;
          state_d = S_PT_WAIT;
        end else begin
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      S_FIN: begin
        if (rnd_q == RND_LAST) begin
          rnd_d   = '0;
          state_d = S_TAG;
        end else begin
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      S_TAG: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        rnd_d   = '0;
        ad_d    = '0;
        pt_d    = '0;
      end
    endcase
    out_d = decode(state_d, rnd_d);
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      ad_q    <= '0;
      pt_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      ad_q    <= ad_d;
      pt_q    <= pt_d;
      out_q   <= out_d;
    end
  end

  assign round_o              = rnd_q;
  assign data_ready_o         = out_q.data_ready;
  assign input_mode_o         = out_q.input_mode;
  assign en_reg_state_o       = out_q.en_reg_state;
  assign xor_data_o           = out_q.xor_data;
  assign xor_key_begin_o      = out_q.xor_key_begin;
  assign xor_key_end_o        = out_q.xor_key_end;
  assign xor_dom_sep_o        = out_q.xor_dom_sep;
  assign en_cipher_o          = out_q.en_cipher;
  assign en_tag_o             = out_q.en_tag;
  assign end_initialisation_o = out_q.end_init;
  assign busy_o               = out_q.busy;
  assign done_o               = out_q.done;

endmodule

// File: tb/tb_fsm_moore_ascon_ctrl.sv
// Bench for fsm_moore_ascon_ctrl: a per-transaction expected-cycle program checked every cycle,
// plus literal latency / pulse-count expectations.
module tb_fsm_moore_ascon_ctrl;
  localparam int PA = 12;
  localparam int PB = 6;

  localparam logic [11:0] M_RDY = 12'h800, M_MODE = 12'h400, M_EN = 12'h200, M_XD = 12'h100;
  localparam logic [11:0] M_KB  = 12'h080, M_KE   = 12'h040, M_DS = 12'h020, M_CI = 12'h010;
  localparam logic [11:0] M_TG  = 12'h008, M_EI   = 12'h004, M_BS = 12'h002, M_DN = 12'h001;

  logic       clk = 1'b0;
  logic       rst_n, start, valid;
  logic [3:0] nb_ad, nb_pt;
  logic       data_ready_o, input_mode_o, en_reg_state_o, xor_data_o, xor_key_begin_o;
  logic       xor_key_end_o, xor_dom_sep_o, en_cipher_o, en_tag_o, end_initialisation_o;
  logic       busy_o, done_o;
  logic [3:0] round_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm_moore_ascon_ctrl #(.PA_ROUNDS(PA), .PB_ROUNDS(PB), .BLK_W(4), .RND_W(4)) dut (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .nb_ad_i(nb_ad), .nb_pt_i(nb_pt),
    .data_valid_i(valid), .data_ready_o(data_ready_o), .round_o(round_o),
    .input_mode_o(input_mode_o), .en_reg_state_o(en_reg_state_o), .xor_data_o(xor_data_o),
    .xor_key_begin_o(xor_key_begin_o), .xor_key_end_o(xor_key_end_o),
    .xor_dom_sep_o(xor_dom_sep_o), .en_cipher_o(en_cipher_o), .en_tag_o(en_tag_o),
    .end_initialisation_o(end_initialisation_o), .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [11:0] actv();
    return {data_ready_o, input_mode_o, en_reg_state_o, xor_data_o, xor_key_begin_o,
            xor_key_end_o, xor_dom_sep_o, en_cipher_o, en_tag_o, end_initialisation_o,
            busy_o, done_o};
  endfunction

  // Model: one entry per expected cycle of a transaction; wait entries only retire on valid.
  typedef struct {
    logic [11:0] o;
    logic [3:0]  r;
    bit          wt;
  } ent_t;
  ent_t prog[$];

  function automatic ent_t ent(input logic [11:0] o, input int r, input bit wt);
    ent_t e;
    e.o  = o | M_BS;
    e.r  = 4'(r);
    e.wt = wt;
    return e;
  endfunction

  task automatic build(input int nad, input int npt0);
    int npt;
    npt = (npt0 == 0) ? 1 : npt0;
    prog.push_back(ent(M_MODE | M_EN, 0, 1'b0));
    for (int k = 0; k < PA; k++)
      prog.push_back(ent(M_EN | ((k == PA - 1) ? (M_KE | M_EI) : 12'h0), 12 - PA + k, 1'b0));
    for (int a = 0; a < nad; a++) begin
      prog.push_back(ent(M_RDY, 0, 1'b1));
      for (int k = 0; k < PB; k++)
        prog.push_back(ent(M_EN | ((k == 0) ? M_XD : 12'h0), 12 - PB + k, 1'b0));
    end
    prog.push_back(ent(M_EN | M_DS, 0, 1'b0));
    for (int p = 0; p < npt; p++) begin
      prog.push_back(ent(M_RDY, 0, 1'b1));
      if (p < npt - 1) begin
        for (int k = 0; k < PB; k++)
          prog.push_back(ent(M_EN | ((k == 0) ? (M_XD | M_CI) : 12'h0), 12 - PB + k, 1'b0));
      end else begin
        for (int k = 0; k < PA; k++)
          prog.push_back(ent(M_EN | ((k == 0) ? (M_XD | M_CI | M_KB) : 12'h0) |
                             ((k == PA - 1) ? M_KE : 12'h0), 12 - PA + k, 1'b0));
      end
    end
    prog.push_back(ent(M_TG | M_DN, 0, 1'b0));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) prog.delete();
    else if (prog.size() == 0) begin
      if (start) build(int'(nb_ad), int'(nb_pt));
    end else if (!(prog[0].wt && !valid)) begin
      void'(prog.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [11:0] eo;
    logic [3:0]  er;
    eo = (prog.size() != 0) ? prog[0].o : 12'h0;
    er = (prog.size() != 0) ? prog[0].r : 4'h0;
    checks++;
    if ({actv(), round_o} !== {eo, er}) begin
      failures++;
      $display("FAIL cycle_model t=%0t got outs=%h round=%0d expected outs=%h round=%0d",
               $time, actv(), round_o, eo, er);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic run_txn(input int ad, input int pt, input int stall, input bit pulse,
                         output int tag, output int nxd, output int nci, output int eic);
    int  n;
    int  left;
    bit  got;
    n = 0; left = stall; got = 0;
    tag = -1; nxd = 0; nci = 0; eic = -1;
    @(posedge clk); #2;
    nb_ad = 4'(ad); nb_pt = 4'(pt); start = 1'b1; valid = 1'b1;
    while (!got && n < 2000) begin
      @(posedge clk); n++; #2;
      start = pulse && (n >= 3) && (n <= 5);
      if (data_ready_o && left > 0) begin
        valid = 1'b0;
        left--;
      end else valid = 1'b1;
      @(negedge clk);
      if (xor_data_o) nxd++;
      if (en_cipher_o) nci++;
      if (end_initialisation_o && eic < 0) eic = n;
      if (done_o) begin
        got = 1;
        tag = n;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL txn_timeout got=no_done expected=done_within_2000");
    end
  endtask

  initial begin
    int tag, nxd, nci, eic;
    bit seen, hit;
    rst_n = 1'b0; start = 1'b1; valid = 1'b1; nb_ad = 4'd0; nb_pt = 4'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'(actv()), 0);
    chk("reset_round", int'(round_o), 0);
    @(posedge clk); #2;
    rst_n = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_without_start", int'(busy_o), 0);

    run_txn(0, 1, 0, 1'b0, tag, nxd, nci, eic);
    chk("ad0_pt1_tag_cycle", tag, 28);
    chk("ad0_pt1_end_init_cycle", eic, 13);
    chk("ad0_pt1_xor_data_pulses", nxd, 1);
    chk("ad0_pt1_cipher_pulses", nci, 1);

    run_txn(2, 3, 0, 1'b0, tag, nxd, nci, eic);
    chk("ad2_pt3_tag_cycle", tag, 56);
    chk("ad2_pt3_xor_data_pulses", nxd, 5);
    chk("ad2_pt3_cipher_pulses", nci, 3);

    run_txn(1, 1, 20, 1'b0, tag, nxd, nci, eic);
    chk("ad1_stall20_tag_cycle", tag, 55);
    chk("ad1_stall20_xor_data_pulses", nxd, 2);

    run_txn(0, 0, 0, 1'b1, tag, nxd, nci, eic);
    chk("pt0_start_pulses_tag_cycle", tag, 28);
    chk("pt0_cipher_pulses", nci, 1);

    // Abort in the third PT_RND round (round 8) of a two-PT-block message.
    @(posedge clk); #2;
    nb_ad = 4'd0; nb_pt = 4'd2; start = 1'b1; valid = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    seen = 0; hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (end_initialisation_o) seen = 1;
      else if (seen && round_o == 4'd8 && en_reg_state_o) hit = 1;
    end
    chk("reached_pt_round8", int'(hit), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'(actv()), 0);
    chk("async_reset_round", int'(round_o), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_after_abort", int'(busy_o), 0);
    run_txn(0, 1, 0, 1'b0, tag, nxd, nci, eic);
    chk("restart_tag_cycle", tag, 28);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
